dram_ctrl: RTL and testbench
============================

Name: dram_ctrl

Overview:
Request-side controller sitting directly upstream of the team's dram array. It accepts single-beat read/write requests over a valid/ready handshake and sequences them into the dram's wr/rd/data strobes with a memory address. Every REF_INTERVAL cycles it also inserts one distributed refresh access, a dummy read of the next row. Read data returns on a one-cycle response pulse with no backpressure.

Parameters:
DATA_W, 8, data width; matches the dram data/out width.
ADDR_W, 4, address width; ROWS = 2**ADDR_W.
RD_LAT, 1, cycles from the mem_rd cycle until mem_out is valid (>=1).
REF_INTERVAL, 64, cycles between refresh requests; must exceed RD_LAT+3.

Ports:
clk  in  1  single clock; all logic on posedge.
rst  in  1  reset, synchronous, active-low (0 = reset).
req_valid  in  1  request present.
req_ready  out  1  controller can accept this cycle.
req_we  in  1  1 = write, 0 = read.
req_addr  in  ADDR_W  request address.
req_wdata  in  DATA_W  write data.
rsp_valid  out  1  one-cycle pulse; rsp_rdata valid.
rsp_rdata  out  DATA_W  read data.
mem_wr  out  1  dram write strobe.
mem_rd  out  1  dram read strobe.
mem_addr  out  ADDR_W  dram address.
mem_data  out  DATA_W  dram write data.
mem_out  in  DATA_W  dram read data.
ref_miss  out  1  sticky error: refresh interval expired while a refresh was still pending.

Behaviour:
- Reset (rst=0 at posedge): state IDLE; req_ready=0 during the reset cycle, then 1 on the first cycle after release. rsp_valid=0, rsp_rdata=0, mem_wr=0, mem_rd=0, mem_addr=0, mem_data=0, ref_miss=0. Refresh counter=0, ref_row=0, ref_pending=0. Reset mid-operation aborts with no response and no strobe in the next cycle.
- All outputs are registered. req_ready = (state==IDLE) && !ref_pending.
- Handshake: a request is accepted at a posedge where req_valid && req_ready. req_addr, req_we and req_wdata are captured then. Requests not accepted are held by the requester; the controller never drops an accepted request.
- FSM states: IDLE, WR, RD, RD_WAIT, REF, REF_WAIT.
- IDLE:
  - If ref_pending, go to REF; refresh has priority over a simultaneous req_valid.
  - Else on accept, go to WR or RD.
- WR: one cycle with mem_wr=1, mem_addr and mem_data from the captured request; then IDLE. Accept in cycle 0 -> mem_wr in cycle 1 -> req_ready=1 in cycle 2. Writes produce no response.
- RD: one cycle with mem_rd=1 and mem_addr=captured address, then RD_WAIT for RD_LAT cycles. At the end of the last wait cycle, register mem_out into rsp_rdata. rsp_valid=1 for exactly one cycle, in the same cycle state returns to IDLE. For RD_LAT=1: accept in cycle 0, mem_rd in cycle 1, rsp_valid in cycle 3.
- REF: one cycle with mem_rd=1 and mem_addr=ref_row; clears ref_pending. Then REF_WAIT for RD_LAT cycles; data is discarded and rsp_valid stays 0. ref_row increments, wrapping ROWS-1 -> 0. Then IDLE.
- Refresh counter: free-running 0..REF_INTERVAL-1, wrapping. At the terminal count, set ref_pending. If ref_pending is already 1 at that point, set ref_miss, which stays 1 until reset.
- mem_wr and mem_rd are never both 1. mem_data holds its last value when mem_wr=0.

Decomposition:
- Shared package dram_pkg holds the state enum (IDLE, WR, RD, RD_WAIT, REF, REF_WAIT), the DATA_W and ADDR_W defaults, and the ROWS derivation, so the dram model and this controller agree on widths.
- One natural sub-module, dram_ref_timer, holds the interval counter, ref_pending, ref_row and ref_miss. It exposes ref_pending, ref_row, and a ref_ack input pulsed in the REF state.

Test Plan:
1. Reset, then write addr 3 = 8'hFF -> mem_wr=1, mem_addr=3, mem_data=FF for exactly 1 cycle, one cycle after accept; req_ready back to 1 two cycles after accept.
2. Write addr 5 = 8'hA5, then read addr 5 with the dram model attached -> rsp_valid one cycle, 3 cycles after the read accept; rsp_rdata=A5; no other rsp pulses.
3. Back-to-back: hold req_valid with 4 alternating W/R requests -> each accepted only when req_ready=1; responses in order; no lost request.
4. Idle for REF_INTERVAL=64 cycles -> mem_rd pulse with mem_addr=0 and no rsp_valid. After 16 intervals the ref_row sequence is 0..15, then wraps to 0.
5. Raise req_valid in the same cycle ref_pending is set -> REF runs first; the request is accepted after REF_WAIT completes; ref_miss stays 0.
6. Assert rst=0 during RD_WAIT -> next cycle all outputs are at reset values, no rsp_valid pulse, and the refresh counter restarts from 0.

Source files
------------

// File: rtl/dram_pkg.sv
// Shared definitions for the dram array and its request-side controller:
// default widths, row count derivation and the controller state encoding.
package dram_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_RD_WAIT,
        ST_REF,
        ST_REF_WAIT
    } state_t;

    function automatic int rows(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/dram_ref_timer.sv
// Distributed refresh scheduler: free-running interval counter, pending flag,
// next row to refresh, and a sticky flag for an interval missed while pending.
module dram_ref_timer
    import dram_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int REF_INTERVAL = 64
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_ref_ack,
    output logic              o_ref_pending,
    output logic              o_ref_pending_nxt,
    output logic [ADDR_W-1:0] o_ref_row,
    output logic              o_ref_miss
);

    localparam int CNT_W = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
    localparam int ROWS  = rows(ADDR_W);

    logic [CNT_W-1:0]  r_cnt;
    logic              r_pending;
    logic              r_miss;
    logic [ADDR_W-1:0] r_row;
    logic              w_terminal;

    assign w_terminal = (r_cnt == CNT_W'(REF_INTERVAL - 1));

    // A new interval expiring wins over an acknowledge landing on the same edge.
    assign o_ref_pending_nxt = w_terminal | (r_pending & ~i_ref_ack);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_pending <= 1'b0;
            r_miss    <= 1'b0;
            r_row     <= '0;
        end else begin
            r_cnt     <= w_terminal ? '0 : r_cnt + 1'b1;
            r_pending <= o_ref_pending_nxt;
            if (w_terminal && r_pending && !i_ref_ack) begin
                r_miss <= 1'b1;
            end
            if (i_ref_ack) begin
                r_row <= (r_row == ADDR_W'(ROWS - 1)) ? '0 : r_row + 1'b1;
            end
        end
    end

    assign o_ref_pending = r_pending;
    assign o_ref_row     = r_row;
    assign o_ref_miss    = r_miss;

endmodule

// File: rtl/dram_ctrl.sv
// Request-side dram controller: sequences single-beat read/write requests and
// periodic refresh reads into registered dram strobes.
module dram_ctrl
    import dram_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int RD_LAT       = 1,
    parameter int REF_INTERVAL = 64
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] mem_out,
    output logic              ref_miss
);

    localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WAIT_W-1:0] r_wait_cnt;

    logic              r_req_ready;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_mem_wr;
    logic              r_mem_rd;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_data;

    logic              w_req_ready_nxt;
    logic              w_rsp_valid_nxt;
    logic [DATA_W-1:0] w_rsp_rdata_nxt;
    logic              w_mem_wr_nxt;
    logic              w_mem_rd_nxt;
    logic [ADDR_W-1:0] w_mem_addr_nxt;
    logic [DATA_W-1:0] w_mem_data_nxt;

    logic              w_accept;
    logic              w_wait_done;
    logic              w_ref_ack;
    logic              w_ref_pending;
    logic              w_ref_pending_nxt;
    logic [ADDR_W-1:0] w_ref_row;
    logic              w_ref_miss;

    dram_ref_timer #(
        .ADDR_W       (ADDR_W),
        .REF_INTERVAL (REF_INTERVAL)
    ) u_ref_timer (
        .clk               (clk),
        .rst               (rst),
        .i_ref_ack         (w_ref_ack),
        .o_ref_pending     (w_ref_pending),
        .o_ref_pending_nxt (w_ref_pending_nxt),
        .o_ref_row         (w_ref_row),
        .o_ref_miss        (w_ref_miss)
    );

    // The registered ready already implies IDLE with no refresh pending.
    assign w_accept    = req_valid && r_req_ready;
    assign w_wait_done = (r_wait_cnt == WAIT_W'(RD_LAT - 1));
    assign w_ref_ack   = (r_state == ST_REF);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_wait_cnt  <= '0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_mem_wr    <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= (r_state == ST_RD_WAIT || r_state == ST_REF_WAIT)
                           ? r_wait_cnt + 1'b1 : '0;
            r_req_ready <= w_req_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_mem_wr    <= w_mem_wr_nxt;
            r_mem_rd    <= w_mem_rd_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_data  <= w_mem_data_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_ref_pending) begin
                    w_state_nxt = ST_REF;
                end else if (w_accept) begin
                    w_state_nxt = req_we ? ST_WR : ST_RD;
                end
            end
            ST_WR:       w_state_nxt = ST_IDLE;
            ST_RD:       w_state_nxt = ST_RD_WAIT;
            ST_RD_WAIT:  w_state_nxt = w_wait_done ? ST_IDLE : ST_RD_WAIT;
            ST_REF:      w_state_nxt = ST_REF_WAIT;
            ST_REF_WAIT: w_state_nxt = w_wait_done ? ST_IDLE : ST_REF_WAIT;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are computed from the next state so they line up with it once registered.
    always_comb begin
        w_req_ready_nxt = (w_state_nxt == ST_IDLE) && !w_ref_pending_nxt;
        w_mem_wr_nxt    = (w_state_nxt == ST_WR);
        w_mem_rd_nxt    = (w_state_nxt == ST_RD) || (w_state_nxt == ST_REF);
        w_rsp_valid_nxt = (r_state == ST_RD_WAIT) && w_wait_done;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_data_nxt  = r_mem_data;
        if (w_rsp_valid_nxt) begin
            w_rsp_rdata_nxt = mem_out;
        end
        if (w_accept) begin
            w_mem_addr_nxt = req_addr;
            if (req_we) begin
                w_mem_data_nxt = req_wdata;
            end
        end else if (r_state == ST_IDLE && w_ref_pending) begin
            w_mem_addr_nxt = w_ref_row;
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign mem_wr    = r_mem_wr;
    assign mem_rd    = r_mem_rd;
    assign mem_addr  = r_mem_addr;
    assign mem_data  = r_mem_data;
    assign ref_miss  = w_ref_miss;

endmodule

// File: tb/tb_dram_ctrl.sv
// Directed bench for dram_ctrl with a one-cycle-latency dram model attached.
module tb_dram_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_we = 1'b0;
    logic [3:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       mem_wr;
    logic       mem_rd;
    logic [3:0] mem_addr;
    logic [7:0] mem_data;
    logic [7:0] mem_out = '0;
    logic       ref_miss;

    logic [7:0] mem [16];
    logic [7:0] rsp_q [$];
    logic [3:0] rd_q [$];
    int         both_cnt = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    int         t = 0;
    int         acc_t = 0;
    int         acc_hist [4];

    dram_ctrl #(
        .DATA_W       (8),
        .ADDR_W       (4),
        .RD_LAT       (1),
        .REF_INTERVAL (64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_wr    (mem_wr),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_out   (mem_out),
        .ref_miss  (ref_miss)
    );

    always #5 clk = ~clk;

    // Dram model: synchronous write, read data valid the cycle after mem_rd.
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_data;
        if (mem_rd) mem_out <= mem[mem_addr];
    end

    always @(posedge clk) begin
        if (rst) begin
            if (rsp_valid) rsp_q.push_back(rsp_rdata);
            if (mem_rd) rd_q.push_back(mem_addr);
            if (mem_rd && mem_wr) both_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic tick_to(input int target);
        while (t < target) tick();
    endtask

    // Applies reset for one edge; afterwards t counts edges since that reset edge.
    task automatic do_reset();
        rst = 1'b0;
        req_valid = 1'b0;
        tick();
        t = 0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_req_ready"}, req_ready, 0);
        check({pfx, "_rsp_valid"}, rsp_valid, 0);
        check({pfx, "_rsp_rdata"}, rsp_rdata, 0);
        check({pfx, "_mem_wr"},    mem_wr,    0);
        check({pfx, "_mem_rd"},    mem_rd,    0);
        check({pfx, "_mem_addr"},  mem_addr,  0);
        check({pfx, "_mem_data"},  mem_data,  0);
        check({pfx, "_ref_miss"},  ref_miss,  0);
    endtask

    // Presents a request, waits (bounded) for ready, and returns just after the accept edge.
    task automatic send(input logic we, input logic [3:0] a, input logic [7:0] d);
        int budget;
        budget = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready && budget < 200) begin
            tick();
            budget++;
        end
        check("ready_within_budget", req_ready, 1);
        tick();
        acc_t = t;
        req_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;

        // 1: reset values, then a single write
        do_reset();
        check_reset_outputs("rst");
        rst = 1'b1;
        tick();
        check("ready_after_release", req_ready, 1);
        send(1'b1, 4'd3, 8'hFF);
        check("wr_strobe", mem_wr, 1);
        check("wr_addr", mem_addr, 3);
        check("wr_data", mem_data, 8'hFF);
        check("wr_no_rd", mem_rd, 0);
        check("wr_ready_low", req_ready, 0);
        tick();
        check("wr_strobe_one_cycle", mem_wr, 0);
        check("wr_ready_back", req_ready, 1);
        check("wr_data_holds", mem_data, 8'hFF);

        // 2: write then read back with latency checks
        rsp_q.delete();
        send(1'b1, 4'd5, 8'hA5);
        tick();
        send(1'b0, 4'd5, 8'h00);
        check("rd_strobe", mem_rd, 1);
        check("rd_addr", mem_addr, 5);
        check("rd_no_wr", mem_wr, 0);
        tick();
        check("rd_no_rsp_early", rsp_valid, 0);
        tick();
        check("rd_rsp_valid", rsp_valid, 1);
        check("rd_rsp_data", rsp_rdata, 8'hA5);
        check("rd_ready_with_rsp", req_ready, 1);
        tick();
        check("rd_rsp_one_cycle", rsp_valid, 0);
        check("rd_rsp_count", rsp_q.size(), 1);

        // 3: back-to-back alternating requests with req_valid held
        rsp_q.delete();
        send(1'b1, 4'd1, 8'h11); acc_hist[0] = acc_t;
        send(1'b0, 4'd1, 8'h00); acc_hist[1] = acc_t;
        send(1'b1, 4'd2, 8'h22); acc_hist[2] = acc_t;
        send(1'b0, 4'd2, 8'h00); acc_hist[3] = acc_t;
        repeat (4) tick();
        check("b2b_gap_wr_rd", acc_hist[1] - acc_hist[0], 2);
        check("b2b_gap_rd_wr", acc_hist[2] - acc_hist[1], 3);
        check("b2b_gap_wr_rd2", acc_hist[3] - acc_hist[2], 2);
        check("b2b_rsp_count", rsp_q.size(), 2);
        check("b2b_rsp0", (rsp_q.size() > 0) ? rsp_q[0] : 8'hxx, 8'h11);
        check("b2b_rsp1", (rsp_q.size() > 1) ? rsp_q[1] : 8'hxx, 8'h22);

        // 4: idle refresh timing and row sequence over 17 intervals
        do_reset();
        rsp_q.delete();
        rd_q.delete();
        rst = 1'b1;
        tick_to(64);
        check("ref_none_early", rd_q.size(), 0);
        check("ref_pending_blocks_ready", req_ready, 0);
        tick();
        check("ref_strobe", mem_rd, 1);
        check("ref_addr0", mem_addr, 0);
        tick();
        check("ref_strobe_one_cycle", mem_rd, 0);
        tick();
        check("ref_ready_back", req_ready, 1);
        tick_to(1090);
        check("ref_count", rd_q.size(), 17);
        for (int i = 0; i < 17; i++) begin
            check($sformatf("ref_row%0d", i), (i < rd_q.size()) ? 32'(rd_q[i]) : 32'hDEAD, i % 16);
        end
        check("ref_no_rsp", rsp_q.size(), 0);
        check("ref_no_miss", ref_miss, 0);

        // 5: request raised as refresh becomes pending; refresh goes first
        do_reset();
        rst = 1'b1;
        tick_to(64);
        check("prio_ready_low", req_ready, 0);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 4'd7;
        req_wdata = 8'h3C;
        tick();
        check("prio_ref_first", mem_rd, 1);
        check("prio_ref_addr", mem_addr, 0);
        check("prio_no_wr", mem_wr, 0);
        send(1'b1, 4'd7, 8'h3C);
        check("prio_accept_time", acc_t, 68);
        check("prio_wr_strobe", mem_wr, 1);
        check("prio_wr_addr", mem_addr, 7);
        check("prio_wr_data", mem_data, 8'h3C);
        check("prio_no_miss", ref_miss, 0);

        // 6: reset during RD_WAIT aborts and restarts the refresh counter
        do_reset();
        rst = 1'b1;
        tick();
        send(1'b1, 4'd2, 8'h5A);
        tick();
        send(1'b0, 4'd2, 8'h00);
        check("abort_rd_strobe", mem_rd, 1);
        tick();
        rst = 1'b0;
        tick();
        check_reset_outputs("abort");
        rsp_q.delete();
        rd_q.delete();
        t = 0;
        rst = 1'b1;
        tick_to(64);
        check("abort_no_rsp", rsp_q.size(), 0);
        check("abort_no_early_ref", rd_q.size(), 0);
        tick();
        check("abort_ref_strobe", mem_rd, 1);
        check("abort_ref_row0", mem_addr, 0);

        check("strobes_exclusive", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
